// File: rtl/axis_packet_fifo_pkg.sv
// rtl/axis_packet_fifo_pkg.sv - shared helpers for the AXI-stream packet FIFO
package axis_fifo_pkg;

    localparam int AXIS_DWIDTH_DEFAULT = 32;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/axis_packet_fifo_if.sv
// rtl/axis_packet_fifo_if.sv - AXI-stream handshake bundle with full-stream modports
interface Axis_If #(
    parameter int DWIDTH = 32
) ();

    logic [DWIDTH-1:0] data;
    logic              valid;
    logic              ready;
    logic              last;

    modport Master_Full (
        output data,
        output valid,
        output last,
        input  ready
    );

    modport Slave_Full (
        input  data,
        input  valid,
        input  last,
        output ready
    );

endinterface

// File: rtl/axis_fifo_regfile.sv
// rtl/axis_fifo_regfile.sv - DEPTH x (DWIDTH+1) storage, sync write, async read
module axis_fifo_regfile #(
    parameter int DWIDTH = 32,
    parameter int DEPTH  = 16
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [DWIDTH:0]          wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [DWIDTH:0]          rdata
);

    // Contents are never reset; the pointers alone define what is valid.
    logic [DWIDTH:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/axis_packet_fifo.sv
// rtl/axis_packet_fifo.sv - AXI-stream FIFO with optional whole-packet gating
module axis_packet_fifo
    import axis_fifo_pkg::*;
#(
    parameter int DWIDTH      = AXIS_DWIDTH_DEFAULT,
    parameter int DEPTH       = 16,
    parameter int PACKET_MODE = 0
) (
    input  logic                   clk,
    input  logic                   reset_n,
    Axis_If.Slave_Full             s_axis,
    Axis_If.Master_Full            m_axis,
    output logic [$clog2(DEPTH):0] level,
    output logic [$clog2(DEPTH):0] packets
);

    localparam int PW = ptr_width(DEPTH);
    localparam int AW = PW - 1;

    typedef struct packed {
        logic              last;
        logic [DWIDTH-1:0] data;
    } entry_t;

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    entry_t        wr_entry;
    entry_t        rd_entry;
    logic          full;
    logic          empty;
    logic          wr_en;
    logic          rd_en;
    logic          pkt_in;
    logic          pkt_out;

    // Same slot index with differing wrap bits means the writer lapped the reader.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[PW-1] != rd_ptr[PW-1]);

    // ready depends only on registered pointers, never on m_axis.ready.
    assign s_axis.ready = !full;
    assign wr_en        = s_axis.valid && !full;
    assign rd_en        = m_axis.valid && m_axis.ready;
    assign pkt_in       = wr_en && s_axis.last;
    assign pkt_out      = rd_en && m_axis.last;

    // A full FIFO releases regardless of packets so over-long packets still drain.
    assign m_axis.valid = !empty && ((PACKET_MODE == 0) || (packets != '0) || full);
    assign m_axis.data  = rd_entry.data;
    assign m_axis.last  = rd_entry.last;

    assign wr_entry.last = s_axis.last;
    assign wr_entry.data = s_axis.data;

    axis_fifo_regfile #(
        .DWIDTH (DWIDTH),
        .DEPTH  (DEPTH)
    ) u_regfile (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_ptr[AW-1:0]),
        .wdata (wr_entry),
        .raddr (rd_ptr[AW-1:0]),
        .rdata (rd_entry)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level   <= '0;
            packets <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_en, rd_en})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
            case ({pkt_in, pkt_out})
                2'b10:   packets <= packets + 1'b1;
                2'b01:   packets <= packets - 1'b1;
                default: packets <= packets;
            endcase
        end
    end

endmodule

// File: tb/tb_axis_packet_fifo.sv
// tb/tb_axis_packet_fifo.sv - self-checking bench for axis_packet_fifo
module tb_axis_packet_fifo;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    always #5 clk = ~clk;

    logic        sel = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic        out_ready = 1'b0;

    Axis_If #(.DWIDTH(32)) a_s ();
    Axis_If #(.DWIDTH(32)) a_m ();
    Axis_If #(.DWIDTH(32)) b_s ();
    Axis_If #(.DWIDTH(32)) b_m ();

    logic [4:0] a_level, a_packets;
    logic [3:0] b_level, b_packets;

    assign a_s.data  = in_data;
    assign a_s.last  = in_last;
    assign a_s.valid = in_valid && !sel;
    assign a_m.ready = out_ready && !sel;
    assign b_s.data  = in_data;
    assign b_s.last  = in_last;
    assign b_s.valid = in_valid && sel;
    assign b_m.ready = out_ready && sel;

    axis_packet_fifo #(.DWIDTH(32), .DEPTH(16), .PACKET_MODE(0)) dut_a (
        .clk(clk), .reset_n(reset_n), .s_axis(a_s), .m_axis(a_m),
        .level(a_level), .packets(a_packets)
    );

    axis_packet_fifo #(.DWIDTH(32), .DEPTH(8), .PACKET_MODE(1)) dut_b (
        .clk(clk), .reset_n(reset_n), .s_axis(b_s), .m_axis(b_m),
        .level(b_level), .packets(b_packets)
    );

    logic        s_ready, m_valid, m_last;
    logic [31:0] m_data;
    logic [4:0]  lvl, pkts;
    assign s_ready = sel ? b_s.ready : a_s.ready;
    assign m_valid = sel ? b_m.valid : a_m.valid;
    assign m_last  = sel ? b_m.last  : a_m.last;
    assign m_data  = sel ? b_m.data  : a_m.data;
    assign lvl     = sel ? {1'b0, b_level}   : a_level;
    assign pkts    = sel ? {1'b0, b_packets} : a_packets;

    typedef struct packed {
        logic        last;
        logic [31:0] data;
    } beat_t;
    beat_t sb[$];

    int n_cmp = 0;
    int n_fail = 0;
    int mdl_level = 0, mdl_packets = 0, mdl_depth = 16;
    bit mdl_mode = 1'b0;

    bit          cur_acc, cur_hs, cur_mv, cur_ml, cur_sr;
    logic [31:0] cur_md;
    int          cur_lv, cur_pk;
    bit          prev_mv = 1'b0, prev_hs = 1'b0, prev_ml = 1'b0;
    logic [31:0] prev_md = '0;

    task automatic fail_line(input string name, input string msg);
        n_cmp++;
        n_fail++;
        if (n_fail <= 50) $display("FAIL %s: %s", name, msg);
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 50) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic select(input bit s);
        sel = s;
        mdl_depth = s ? 8 : 16;
        mdl_mode = s;
        prev_mv = 1'b0;
        prev_hs = 1'b0;
    endtask

    // One clock: drive at negedge, sample 1 unit later, then fold handshakes into the model.
    task automatic step(input bit v, input logic [31:0] d, input bit l, input bit r);
        beat_t e;
        @(negedge clk);
        in_valid = v; in_data = d; in_last = l; out_ready = r;
        #1;
        cur_sr = s_ready; cur_mv = m_valid; cur_md = m_data; cur_ml = m_last;
        cur_lv = int'(lvl); cur_pk = int'(pkts);
        check("s_ready", cur_sr, mdl_level != mdl_depth);
        check("m_valid", cur_mv, (mdl_level != 0) &&
              (!mdl_mode || mdl_packets > 0 || mdl_level == mdl_depth));
        check("level", cur_lv, mdl_level);
        check("packets", cur_pk, mdl_packets);
        if (prev_mv && !prev_hs) begin
            check("valid_hold", cur_mv, 1);
            check("data_hold", cur_md, prev_md);
            check("last_hold", cur_ml, prev_ml);
        end
        cur_acc = v && cur_sr;
        cur_hs = cur_mv && r;
        if (cur_hs) begin
            if (sb.size() == 0) begin
                fail_line("sb_underflow", $sformatf("got beat %0h expected none", cur_md));
            end else begin
                e = sb.pop_front();
                check("out_data", cur_md, e.data);
                check("out_last", cur_ml, e.last);
                if (e.last) mdl_packets--;
            end
        end
        if (cur_acc) begin
            sb.push_back({l, d});
            if (l) mdl_packets++;
        end
        mdl_level += int'(cur_acc) - int'(cur_hs);
        prev_mv = cur_mv; prev_hs = cur_hs; prev_md = cur_md; prev_ml = cur_ml;
    endtask

    task automatic run_random(input bit s, input int n);
        int sent = 0;
        bit v, l;
        select(s);
        for (int c = 0; c < 40000 && !(sent == n && sb.size() == 0); c++) begin
            v = (sent < n) && ($urandom_range(0, 1) == 1);
            l = s ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 1) == 1);
            if (sent == n - 1) l = 1'b1;
            step(v, 32'(1000 + sent), l, $urandom_range(0, 1) == 1);
            if (cur_acc) sent++;
        end
        check("random_sent", sent, n);
        check("random_drained", sb.size(), 0);
    endtask

    typedef struct {
        bit          v;
        logic [31:0] d;
        bit          l;
        bit          r;
        bit          e_mv;
        bit          e_sr;
        int          e_lv;
        int          e_pk;
        logic [31:0] e_md;
    } vec_t;
    vec_t tbl[12];

    initial begin
        int idx;
        bit first_seen;

        tbl[0]  = '{1, 1, 0, 1, 0, 1, 0, 0, 0};
        tbl[1]  = '{1, 2, 0, 1, 0, 1, 1, 0, 0};
        tbl[2]  = '{1, 3, 0, 1, 0, 1, 2, 0, 0};
        tbl[3]  = '{1, 4, 0, 1, 0, 1, 3, 0, 0};
        tbl[4]  = '{1, 5, 1, 1, 0, 1, 4, 0, 0};
        tbl[5]  = '{0, 0, 0, 0, 1, 1, 5, 1, 1};
        tbl[6]  = '{0, 0, 0, 1, 1, 1, 5, 1, 1};
        tbl[7]  = '{0, 0, 0, 1, 1, 1, 4, 1, 2};
        tbl[8]  = '{0, 0, 0, 1, 1, 1, 3, 1, 3};
        tbl[9]  = '{0, 0, 0, 1, 1, 1, 2, 1, 4};
        tbl[10] = '{0, 0, 0, 1, 1, 1, 1, 1, 5};
        tbl[11] = '{0, 0, 0, 0, 0, 1, 0, 0, 0};

        #1 reset_n = 1'b0;
        #2;
        check("rst_a_ready", a_s.ready, 1);
        check("rst_a_valid", a_m.valid, 0);
        check("rst_a_level", a_level, 0);
        check("rst_b_ready", b_s.ready, 1);
        check("rst_b_valid", b_m.valid, 0);
        check("rst_b_packets", b_packets, 0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        // Streaming through the plain FIFO with an always-ready sink.
        select(0);
        for (int i = 0; i <= 100; i++) begin
            step(i < 100, 32'(i), (i % 10) == 9, 1'b1);
            if (i >= 1) begin
                check("stream_valid", cur_mv, 1);
                check("stream_no_bubble", cur_hs, 1);
            end
            check("stream_level_le1", cur_lv <= 1, 1);
        end
        check("stream_drained", sb.size(), 0);

        // Fill with a stalled sink, then release.
        idx = 0;
        for (int c = 0; c < 20; c++) begin
            step(1'b1, 32'(200 + idx), 1'b0, 1'b0);
            if (cur_acc) idx++;
        end
        check("fill_accepted", idx, 16);
        step(1'b1, 32'(200 + idx), 1'b0, 1'b1);
        check("full_level", cur_lv, 16);
        check("full_ready_low", cur_sr, 0);
        check("full_read", cur_hs, 1);
        for (int c = 0; c < 100 && !(idx == 20 && sb.size() == 0); c++) begin
            step(idx < 20, 32'(200 + idx), 1'b0, 1'b1);
            if (cur_acc) idx++;
        end
        check("drain_accepted", idx, 20);
        check("drain_empty", sb.size(), 0);

        // Packet gating table on the DEPTH=8 packet-mode instance.
        select(1);
        foreach (tbl[k]) begin
            step(tbl[k].v, tbl[k].d, tbl[k].l, tbl[k].r);
            check($sformatf("tbl%0d_m_valid", k), cur_mv, tbl[k].e_mv);
            check($sformatf("tbl%0d_s_ready", k), cur_sr, tbl[k].e_sr);
            check($sformatf("tbl%0d_level", k), cur_lv, tbl[k].e_lv);
            check($sformatf("tbl%0d_packets", k), cur_pk, tbl[k].e_pk);
            if (tbl[k].e_mv) check($sformatf("tbl%0d_data", k), cur_md, tbl[k].e_md);
        end

        // Packet longer than DEPTH must be force-released when full.
        idx = 0;
        first_seen = 1'b0;
        for (int c = 0; c < 80 && !(idx == 12 && sb.size() == 0); c++) begin
            step(idx < 12, 32'(300 + idx), idx == 11, 1'b1);
            if (cur_acc) idx++;
            if (cur_mv && !first_seen) begin
                first_seen = 1'b1;
                check("release_level", cur_lv, 8);
            end
        end
        check("release_seen", first_seen, 1);
        check("release_sent", idx, 12);
        check("release_drained", sb.size(), 0);

        run_random(1'b0, 3000);
        run_random(1'b1, 3000);

        // Mid-operation reset with one whole packet and a partial one stored.
        for (int i = 0; i < 7; i++) step(1'b1, 32'(500 + i), i == 2, 1'b0);
        step(1'b0, 32'd0, 1'b0, 1'b0);
        check("pre_rst_level", cur_lv, 7);
        check("pre_rst_packets", cur_pk, 1);
        check("pre_rst_valid", cur_mv, 1);
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b0;
        reset_n = 1'b0;
        #1;
        check("async_rst_valid", m_valid, 0);
        check("async_rst_ready", s_ready, 1);
        check("async_rst_level", lvl, 0);
        check("async_rst_packets", pkts, 0);
        sb.delete();
        mdl_level = 0;
        mdl_packets = 0;
        prev_mv = 1'b0;
        prev_hs = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) step(1'b1, 32'(600 + i), i == 3, 1'b1);
        for (int c = 0; c < 10 && sb.size() != 0; c++) step(1'b0, 32'd0, 1'b0, 1'b1);
        check("post_rst_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule
